// File: rtl/kgp_ctrl_pkg.sv
// Shared encodings for the KGP-RISC multi-cycle controller: states, opcode and
// function-code classes, and write-back source selects.
package kgp_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [2:0] OP_ALU  = 3'd0;
    localparam logic [2:0] OP_ALUI = 3'd1;
    localparam logic [2:0] OP_MEM  = 3'd2;
    localparam logic [2:0] OP_BR   = 3'd3;
    localparam logic [2:0] OP_HALT = 3'd7;

    localparam logic [3:0] FC_LW = 4'd0;
    localparam logic [3:0] FC_SW = 4'd1;
    localparam logic [3:0] FC_BL = 4'd9;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_RA  = 2'd2;

    // HALT is classified separately; this only answers whether EXEC may follow.
    function automatic logic op_legal(input logic [2:0] op, input logic [3:0] fc);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_ALU, OP_ALUI, OP_BR: ok = 1'b1;
            OP_MEM:                 ok = (fc == FC_LW) || (fc == FC_SW);
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/kgp_mem_wait_timer.sv
// Memory-stall watchdog: counts cycles spent waiting on mem_ready in an access
// state and flags the final permitted cycle when ready still has not arrived.
module kgp_mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    input  logic ready,
    output logic timeout
);

    localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (active && !ready) begin
            count <= count + 1'b1;
        end
    end

    // Ready in the last cycle wins: timeout only fires while ready is low.
    assign timeout = (MEM_TIMEOUT != 0) && active && !ready && (count == LAST);

endmodule

// File: rtl/kgp_mc_ctrl.sv
// Multi-cycle control FSM for the KGP-RISC core: sequences fetch, decode,
// execute, memory and write-back over one shared memory port.
module kgp_mc_ctrl
    import kgp_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [3:0]       fcode,
    input  logic             cond_true,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             mdr_we,
    output logic             alu_en,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             wb_en,
    output logic [1:0]       wb_sel,
    output logic [2:0]       state,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    state_t cur, nxt;
    logic   timeout;
    logic   wait_active;
    logic   wait_clear;
    logic   is_lw;
    logic   is_bl;

    assign is_lw = (opcode == OP_MEM) && (fcode == FC_LW);
    assign is_bl = (opcode == OP_BR) && (fcode == FC_BL);

    assign wait_active = (cur == S_FETCH) || (cur == S_MEM);
    assign wait_clear  = ((nxt == S_FETCH) || (nxt == S_MEM)) && (nxt != cur);

    kgp_mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait (
        .clk    (clk),
        .rst    (rst),
        .clear  (wait_clear),
        .active (wait_active),
        .ready  (mem_ready),
        .timeout(timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= S_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt          = cur;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        mdr_we       = 1'b0;
        alu_en       = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        wb_en        = 1'b0;
        wb_sel       = WB_ALU;
        halted       = 1'b0;
        err          = 1'b0;
        case (cur)
            S_IDLE: begin
                if (start) nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                if (mem_ready)    nxt = S_DECODE;
                else if (timeout) nxt = S_ERR;
            end
            S_DECODE: begin
                if (opcode == OP_HALT)           nxt = S_HALT;
                else if (!op_legal(opcode, fcode)) nxt = S_ERR;
                else                             nxt = S_EXEC;
            end
            S_EXEC: begin
                alu_en = 1'b1;
                pc_we  = 1'b1;
                if (opcode == OP_BR) pc_sel = is_bl | cond_true;
                if (opcode == OP_MEM)
                    nxt = S_MEM;
                else if ((opcode == OP_ALU) || (opcode == OP_ALUI) || is_bl)
                    nxt = S_WB;
                else
                    nxt = S_FETCH;
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (fcode == FC_SW);
                mdr_we       = mem_ready && is_lw;
                if (mem_ready)    nxt = is_lw ? S_WB : S_FETCH;
                else if (timeout) nxt = S_ERR;
            end
            S_WB: begin
                wb_en  = 1'b1;
                wb_sel = is_lw ? WB_MEM : (is_bl ? WB_RA : WB_ALU);
                nxt    = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            S_ERR:  err    = 1'b1;
        endcase
    end

    assign state = cur;

    // An instruction retires whenever control returns to FETCH from its last phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if ((nxt == S_FETCH) &&
                     ((cur == S_EXEC) || (cur == S_MEM) || (cur == S_WB))) begin
            retired <= retired + 1'b1;
        end
    end

endmodule

// File: tb/tb_kgp_mc_ctrl.sv
// Self-checking bench for kgp_mc_ctrl: table vectors, randomized instruction
// stream against a spec-level model, and hand sequences for terminal states.
module tb_kgp_mc_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  opcode;
    logic [3:0]  fcode;
    logic        cond_true;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_we;
    logic        mdr_we;
    logic        alu_en;
    logic        pc_we;
    logic        pc_sel;
    logic        wb_en;
    logic [1:0]  wb_sel;
    logic [2:0]  state;
    logic        halted;
    logic        err;
    logic [31:0] retired;
    logic [15:0] outs;

    kgp_mc_ctrl #(
        .MEM_TIMEOUT(16),
        .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .fcode(fcode),
        .cond_true(cond_true), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
        .mdr_we(mdr_we), .alu_en(alu_en), .pc_we(pc_we), .pc_sel(pc_sel),
        .wb_en(wb_en), .wb_sel(wb_sel), .state(state), .halted(halted),
        .err(err), .retired(retired)
    );

    assign outs = {mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, alu_en, pc_we,
                   pc_sel, wb_en, wb_sel, state, halted, err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ret = 0;

    typedef struct {
        logic [2:0] op;
        logic [3:0] fc;
        logic       cond;
        int         flat;
        int         mlat;
        int         cycles;
        logic       pc_sel;
        int         wb_n;
        logic [1:0] wb_sel;
        int         mdr_n;
        int         memw_n;
        int         addr_n;
    } vec_t;

    typedef struct {
        logic [2:0] op;
        logic [3:0] fc;
        logic [2:0] term;
    } term_t;

    vec_t  vecs[10];
    term_t terms[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected behaviour of one instruction, derived from its class alone.
    function automatic vec_t model(input logic [2:0] op, input logic [3:0] fc,
                                   input logic cond, input int flat, input int mlat);
        vec_t v;
        bit mem = (op == 3'd2);
        bit lw  = mem && (fc == 4'd0);
        bit sw  = mem && (fc == 4'd1);
        bit bl  = (op == 3'd3) && (fc == 4'd9);
        bit br  = (op == 3'd3) && !bl;
        bit alu = (op <= 3'd1);
        v.op     = op;
        v.fc     = fc;
        v.cond   = cond;
        v.flat   = flat;
        v.mlat   = mlat;
        v.wb_n   = (alu || lw || bl) ? 1 : 0;
        v.cycles = flat + 2 + (mem ? mlat : 0) + v.wb_n;
        v.pc_sel = bl ? 1'b1 : (br ? cond : 1'b0);
        v.wb_sel = alu ? 2'd0 : (lw ? 2'd1 : 2'd2);
        v.mdr_n  = lw ? 1 : 0;
        v.memw_n = sw ? mlat : 0;
        v.addr_n = mem ? mlat : 0;
        return v;
    endfunction

    // Entry and exit: just after a rising edge, with the DUT expected in FETCH.
    task automatic run_instr(input vec_t v, input bit noise);
        int cyc = 0, fcnt = 0, mcnt = 0;
        int wb_n = 0, pc_n = 0, mdr_n = 0, memw_n = 0, addr_n = 0;
        int ir_n = 0, alu_n = 0, req_n = 0;
        logic ps = 1'b0;
        logic [1:0] ws = 2'd0;
        logic [2:0] st;
        int tq[$];
        int eq[$];
        bit done = 0;
        bit ok;
        opcode = v.op; fcode = v.fc; cond_true = v.cond;
        while (!done && cyc < 64) begin
            st = state;
            tq.push_back(int'(st));
            if (st == 3'd1)      mem_ready = (fcnt == v.flat - 1);
            else if (st == 3'd4) mem_ready = (mcnt == v.mlat - 1);
            else                 mem_ready = noise ? 1'($urandom) : 1'b0;
            @(negedge clk);
            if (wb_en)  begin wb_n++; ws = wb_sel; end
            if (pc_we)  begin pc_n++; ps = pc_sel; end
            if (mdr_we) mdr_n++;
            if (ir_we)  ir_n++;
            if (alu_en) alu_n++;
            if (mem_req) req_n++;
            if (mem_req && mem_we) memw_n++;
            if (mem_req && mem_addr_sel) addr_n++;
            if (st == 3'd1) fcnt++;
            if (st == 3'd4) mcnt++;
            cyc++;
            @(posedge clk); #1;
            if (state == 3'd1 && st != 3'd1) done = 1;
        end
        mem_ready = 1'b0;
        for (int i = 0; i < v.flat; i++) eq.push_back(1);
        eq.push_back(2);
        eq.push_back(3);
        if (v.op == 3'd2) for (int i = 0; i < v.mlat; i++) eq.push_back(4);
        if (v.wb_n > 0) eq.push_back(5);
        ok = (tq.size() == eq.size());
        if (ok) for (int i = 0; i < eq.size(); i++) if (tq[i] != eq[i]) ok = 0;
        check("back_to_fetch", done, 1);
        check("state_trace", ok, 1);
        check("cycles", cyc, v.cycles);
        check("ir_we_pulses", ir_n, 1);
        check("alu_en_cycles", alu_n, 1);
        check("pc_we_pulses", pc_n, 1);
        if (pc_n > 0) check("pc_sel", ps, v.pc_sel);
        check("wb_en_pulses", wb_n, v.wb_n);
        if (wb_n > 0) check("wb_sel", ws, v.wb_sel);
        check("mdr_we_pulses", mdr_n, v.mdr_n);
        check("mem_we_cycles", memw_n, v.memw_n);
        check("mem_addr_alu_cycles", addr_n, v.addr_n);
        check("mem_req_cycles", req_n, v.flat + v.addr_n);
        exp_ret++;
        check("retired", retired, exp_ret);
    endtask

    task automatic go_fetch();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("enter_fetch", state, 3'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        check("reset_state", state, 3'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ret = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{3'd0, 4'd0, 1'b0, 1,  1,  4, 1'b0, 1, 2'd0, 0, 0, 0};
        vecs[1] = '{3'd2, 4'd0, 1'b0, 2,  2,  7, 1'b0, 1, 2'd1, 1, 0, 2};
        vecs[2] = '{3'd2, 4'd1, 1'b0, 1,  1,  4, 1'b0, 0, 2'd0, 0, 1, 1};
        vecs[3] = '{3'd3, 4'd9, 1'b0, 1,  1,  4, 1'b1, 1, 2'd2, 0, 0, 0};
        vecs[4] = '{3'd3, 4'd2, 1'b0, 1,  1,  3, 1'b0, 0, 2'd0, 0, 0, 0};
        vecs[5] = '{3'd3, 4'd2, 1'b1, 1,  1,  3, 1'b1, 0, 2'd0, 0, 0, 0};
        vecs[6] = '{3'd1, 4'd5, 1'b0, 16, 1, 19, 1'b0, 1, 2'd0, 0, 0, 0};
        vecs[7] = '{3'd2, 4'd0, 1'b1, 1, 16, 20, 1'b0, 1, 2'd1, 1, 0, 16};
        vecs[8] = '{3'd2, 4'd1, 1'b0, 2,  3,  7, 1'b0, 0, 2'd0, 0, 3, 3};
        vecs[9] = '{3'd0, 4'd9, 1'b1, 1,  1,  4, 1'b0, 1, 2'd0, 0, 0, 0};
        terms[0] = '{3'd7, 4'd0, 3'd6};
        terms[1] = '{3'd5, 4'd0, 3'd7};
        terms[2] = '{3'd2, 4'd3, 3'd7};
        terms[3] = '{3'd4, 4'd0, 3'd7};
        terms[4] = '{3'd6, 4'd1, 3'd7};

        rst = 1'b1; start = 1'b0; mem_ready = 1'b0;
        opcode = '0; fcode = '0; cond_true = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_outputs", outs, 16'h0);
        check("rst_retired", retired, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        @(negedge clk);
        check("idle_hold", state, 3'd0);
        check("idle_no_req", mem_req, 1'b0);

        go_fetch();
        foreach (vecs[i]) run_instr(vecs[i], 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            logic [3:0] fc;
            op = 3'($urandom_range(0, 3));
            fc = (op == 3'd2) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15));
            run_instr(model(op, fc, 1'($urandom), int'($urandom_range(1, 4)),
                            int'($urandom_range(1, 4))), 1'b1);
        end

        // FETCH watchdog: ready never arrives.
        begin
            int infetch = 0;
            mem_ready = 1'b0;
            start = 1'b1;
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                if (state == 3'd1) infetch++;
                @(posedge clk); #1;
            end
            @(negedge clk);
            check("wd_fetch_cycles", infetch, 16);
            check("wd_fetch_err_state", state, 3'd7);
            check("wd_fetch_err", err, 1'b1);
            check("wd_fetch_no_req", mem_req, 1'b0);
            mem_ready = 1'b1;
            repeat (3) begin @(posedge clk); #1; end
            @(negedge clk);
            check("err_sticky", state, 3'd7);
            start = 1'b0;
            do_reset();
        end

        // MEM watchdog on a load.
        begin
            int inmem = 0;
            go_fetch();
            opcode = 3'd2; fcode = 4'd0; mem_ready = 1'b1;
            @(posedge clk); #1; mem_ready = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                if (state == 3'd4) inmem++;
                @(posedge clk); #1;
            end
            @(negedge clk);
            check("wd_mem_cycles", inmem, 16);
            check("wd_mem_err_state", state, 3'd7);
            check("wd_mem_retired", retired, 0);
            do_reset();
        end

        foreach (terms[i]) begin
            go_fetch();
            opcode = terms[i].op; fcode = terms[i].fc; mem_ready = 1'b1;
            @(posedge clk); #1; mem_ready = 1'b0;
            @(negedge clk);
            check("term_decode", state, 3'd2);
            @(posedge clk); #1;
            @(negedge clk);
            check("term_state", state, terms[i].term);
            check("term_halted", halted, terms[i].term == 3'd6);
            check("term_err", err, terms[i].term == 3'd7);
            check("term_no_req", mem_req, 1'b0);
            start = 1'b1; mem_ready = 1'b1;
            repeat (2) begin @(posedge clk); #1; end
            @(negedge clk);
            check("term_sticky", state, terms[i].term);
            do_reset();
        end

        // Asynchronous reset in the middle of a load's memory phase.
        go_fetch();
        run_instr(vecs[0], 1'b0);
        opcode = 3'd2; fcode = 4'd0; mem_ready = 1'b1;
        @(posedge clk); #1; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_mem_req", mem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_outputs", outs, 16'h0);
        check("async_rst_retired", retired, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
